// File: rtl/memaccess_sequencer.sv
// Data-memory access sequencer: arbitrates the address bus between PC and
// TX, sequences OE/WE with wait states, and stalls fetch during data access.
module memaccess_sequencer #(
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ,
    input  logic REQ_WRITE,
    input  logic HALT,
    output logic PC_ASSERT_bar,
    output logic TX_ASSERT_ADDR_bar,
    output logic MEM_OE_bar,
    output logic MEM_WE_bar,
    output logic DATA_LOAD,
    output logic STALL,
    output logic BUSY,
    output logic DONE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT);

    logic [1:0] state;
    logic       dir;
    logic [3:0] cnt;

    // State, direction and wait counter; DIR latched only on acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            dir   <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (REQ && !HALT) begin
                        dir   <= REQ_WRITE;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt   <= dir ? WR_LOAD : RD_LOAD;
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1)
                        state <= S_RECOVER;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from state, direction and counter.
    always_comb begin
        PC_ASSERT_bar      = 1'b0;
        TX_ASSERT_ADDR_bar = 1'b1;
        MEM_OE_bar         = 1'b0;
        MEM_WE_bar         = 1'b1;
        DATA_LOAD          = 1'b0;
        STALL              = 1'b0;
        BUSY               = 1'b0;
        DONE               = 1'b0;
        case (state)
            S_SETUP: begin
                PC_ASSERT_bar      = 1'b1;
                TX_ASSERT_ADDR_bar = 1'b0;
                MEM_OE_bar         = dir;
                STALL              = 1'b1;
                BUSY               = 1'b1;
            end
            S_ACCESS: begin
                PC_ASSERT_bar      = 1'b1;
                TX_ASSERT_ADDR_bar = 1'b0;
                MEM_OE_bar         = dir;
                MEM_WE_bar         = ~dir;
                DATA_LOAD          = ~dir && (cnt == 4'd1);
                STALL              = 1'b1;
                BUSY               = 1'b1;
            end
            S_RECOVER: begin
                STALL = 1'b1;
                BUSY  = 1'b1;
                DONE  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memaccess_sequencer.sv
// Bench for memaccess_sequencer: fixed vector table, hand sequences and
// randomized traffic against a timeline-based reference model.
module tb_memaccess_sequencer;

    localparam int RW = 1;
    localparam int WW = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ = 1'b0;
    logic REQ_WRITE = 1'b0;
    logic HALT = 1'b0;
    logic PC_ASSERT_bar, TX_ASSERT_ADDR_bar, MEM_OE_bar, MEM_WE_bar;
    logic DATA_LOAD, STALL, BUSY, DONE;

    int vec_cnt = 0;
    int miss_cnt = 0;

    memaccess_sequencer #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ(REQ),
        .REQ_WRITE(REQ_WRITE),
        .HALT(HALT),
        .PC_ASSERT_bar(PC_ASSERT_bar),
        .TX_ASSERT_ADDR_bar(TX_ASSERT_ADDR_bar),
        .MEM_OE_bar(MEM_OE_bar),
        .MEM_WE_bar(MEM_WE_bar),
        .DATA_LOAD(DATA_LOAD),
        .STALL(STALL),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Model: an access is a timeline of W+2 cycles; k is the position in it.
    // k=0 setup, k=1..W strobe window, k=W+1 recover.
    bit m_act = 0;
    int m_k = 0;
    bit m_dir = 0;

    function automatic int wait_of(bit d);
        return d ? WW : RW;
    endfunction

    function automatic logic [7:0] model_out();
        logic pc, tx, oe, we, dl, st, bz, dn;
        int w;
        pc = 0; tx = 1; oe = 0; we = 1; dl = 0; st = 0; bz = 0; dn = 0;
        if (m_act) begin
            w = wait_of(m_dir);
            st = 1; bz = 1;
            if (m_k <= w) begin
                pc = 1; tx = 0; oe = m_dir;
            end
            if (m_k >= 1 && m_k <= w && m_dir) we = 0;
            if (!m_dir && m_k == w) dl = 1;
            if (m_k == w + 1) dn = 1;
        end
        return {pc, tx, oe, we, dl, st, bz, dn};
    endfunction

    function automatic logic [7:0] dut_out();
        return {PC_ASSERT_bar, TX_ASSERT_ADDR_bar, MEM_OE_bar, MEM_WE_bar,
                DATA_LOAD, STALL, BUSY, DONE};
    endfunction

    task automatic model_edge(input logic r, q, w, h);
        if (r) begin
            m_act = 0;
            m_k = 0;
        end else if (!m_act) begin
            if (q && !h) begin
                m_act = 1;
                m_k = 0;
                m_dir = w;
            end
        end else begin
            m_k++;
            if (m_k > wait_of(m_dir) + 1) begin
                m_act = 0;
                m_k = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, q, w, h);
        RST = r; REQ = q; REQ_WRITE = w; HALT = h;
        @(posedge CLK);
        model_edge(r, q, w, h);
        #1;
    endtask

    // Bus invariants sampled away from the active edge every cycle.
    always @(negedge CLK) begin
        if (PC_ASSERT_bar === TX_ASSERT_ADDR_bar) begin
            miss_cnt++;
            $display("FAIL addr_owner: pc=%b tx=%b", PC_ASSERT_bar,
                     TX_ASSERT_ADDR_bar);
        end
        if (MEM_WE_bar === 1'b0 && MEM_OE_bar !== 1'b1) begin
            miss_cnt++;
            $display("FAIL oe_we: oe=%b we=%b", MEM_OE_bar, MEM_WE_bar);
        end
    end

    typedef struct {
        logic       rst, req, wr, halt;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] O_IDLE = 8'b01010000;
    localparam logic [7:0] O_SU_R = 8'b10010110;
    localparam logic [7:0] O_AC_R = 8'b10011110;
    localparam logic [7:0] O_SU_W = 8'b10110110;
    localparam logic [7:0] O_AC_W = 8'b10100110;
    localparam logic [7:0] O_RECV = 8'b01010111;

    vec_t tbl[$];

    task automatic run_access(input logic wr, input string name);
        int busy_n, tx_n, we_n, dl_n, cyc;
        bit seen;
        busy_n = 0; tx_n = 0; we_n = 0; dl_n = 0; seen = 0;
        step(1, 0, 0, 0);
        step(0, 1, wr, 0);
        for (cyc = 0; cyc < 20; cyc++) begin
            check({name, "_cyc"}, dut_out(), model_out());
            busy_n += int'(BUSY);
            tx_n += int'(!TX_ASSERT_ADDR_bar);
            we_n += int'(!MEM_WE_bar);
            dl_n += int'(DATA_LOAD);
            if (DONE) begin
                seen = 1;
                break;
            end
            step(0, 1, ~wr, 0);
        end
        check_int({name, "_done_seen"}, int'(seen), 1);
        check_int({name, "_busy_len"}, busy_n, wait_of(wr) + 2);
        check_int({name, "_tx_len"}, tx_n, wait_of(wr) + 1);
        check_int({name, "_we_len"}, we_n, wr ? WW : 0);
        check_int({name, "_dl_cnt"}, dl_n, wr ? 0 : 1);
        step(0, 0, 0, 0);
        check({name, "_idle"}, dut_out(), O_IDLE);
    endtask

    initial begin
        tbl.push_back('{1, 1, 0, 0, O_IDLE});
        tbl.push_back('{1, 1, 0, 0, O_IDLE});
        tbl.push_back('{0, 1, 0, 0, O_SU_R});
        tbl.push_back('{0, 0, 0, 0, O_AC_R});
        tbl.push_back('{0, 0, 0, 0, O_RECV});
        tbl.push_back('{0, 0, 0, 0, O_IDLE});
        tbl.push_back('{0, 1, 1, 0, O_SU_W});
        tbl.push_back('{0, 1, 0, 0, O_AC_W});
        tbl.push_back('{0, 1, 0, 0, O_AC_W});
        tbl.push_back('{0, 1, 0, 0, O_RECV});
        tbl.push_back('{0, 1, 0, 0, O_IDLE});
        tbl.push_back('{0, 1, 0, 0, O_SU_R});
        tbl.push_back('{0, 0, 0, 1, O_AC_R});
        tbl.push_back('{0, 0, 0, 1, O_RECV});
        tbl.push_back('{0, 1, 0, 1, O_IDLE});
        tbl.push_back('{0, 1, 0, 1, O_IDLE});
        tbl.push_back('{0, 1, 1, 1, O_IDLE});
        tbl.push_back('{0, 1, 1, 0, O_SU_W});
        tbl.push_back('{0, 1, 1, 0, O_AC_W});
        tbl.push_back('{0, 1, 1, 0, O_AC_W});
        tbl.push_back('{1, 1, 1, 0, O_IDLE});
        tbl.push_back('{0, 0, 0, 0, O_IDLE});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].wr, tbl[i].halt);
            check($sformatf("tbl%0d", i), dut_out(), tbl[i].exp);
        end

        run_access(0, "read");
        run_access(1, "write");

        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic r, q, w, h;
            r = ($urandom_range(0, 39) == 0);
            q = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            h = ($urandom_range(0, 5) == 0);
            step(r, q, w, h);
            check($sformatf("rand%0d", i), dut_out(), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/memaccess_sequencer.md
# memaccess_sequencer

Data-memory access sequencer for the 8-bit pipelined processor. It arbitrates the 16-bit memory address bus between the program counter (instruction fetch) and the transfer register (data load/store). It sequences memory output-enable and write-enable with parameterised wait states, and stalls the fetch pipeline and PC increment while a data access owns the memory buses. It sits between pipeline stage 2 control outputs and the memory, PC and transfer-register control inputs.

## Interface
Parameters:
- READ_WAIT, 1: cycles the memory output is enabled for a read before DATA_LOAD; legal range 1..15.
- WRITE_WAIT, 2: cycles MEM_WE_bar is held low for a write; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- REQ  input  1  data access request from pipeline stage 2; level, held until DONE.
- REQ_WRITE  input  1  1 = store (main bus to memory), 0 = load; sampled with REQ.
- HALT  input  1  processor halt; blocks acceptance of new requests.
- PC_ASSERT_bar  output  1  PC drives address bus when 0.
- TX_ASSERT_ADDR_bar  output  1  transfer register drives address bus when 0.
- MEM_OE_bar  output  1  memory drives data bus when 0.
- MEM_WE_bar  output  1  memory write strobe, active low.
- DATA_LOAD  output  1  one-cycle pulse; destination register latches the memory data bus.
- STALL  output  1  freezes the pipeline stages and inhibits PC increment.
- BUSY  output  1  access in progress, which covers any state other than IDLE.
- DONE  output  1  one-cycle pulse at end of access.

## Operation
- Moore FSM. All outputs are decoded from registered state, direction bit and counter, so there are no combinational paths from inputs to outputs.
- States are IDLE, SETUP, ACCESS and RECOVER. The direction register DIR holds a copy of REQ_WRITE. CNT is a 4-bit down-counter.
- IDLE:
  - Outputs: PC_ASSERT_bar=0, TX_ASSERT_ADDR_bar=1, MEM_OE_bar=0, MEM_WE_bar=1, STALL=0, BUSY=0.
  - If REQ=1 and HALT=0: DIR<=REQ_WRITE, go to SETUP. Otherwise remain in IDLE.
- SETUP (1 cycle):
  - Outputs: PC_ASSERT_bar=1, TX_ASSERT_ADDR_bar=0, MEM_OE_bar=DIR, MEM_WE_bar=1, STALL=1, BUSY=1.
  - CNT<=DIR ? WRITE_WAIT : READ_WAIT. Go to ACCESS.
- ACCESS:
  - Address bus is driven by TX. STALL=1, BUSY=1.
  - Read: MEM_OE_bar=0, MEM_WE_bar=1.
  - Write: MEM_OE_bar=1, MEM_WE_bar=0.
  - CNT decrements each cycle. When CNT=1: DATA_LOAD=1 if DIR=0, and the next state is RECOVER.
- RECOVER (1 cycle):
  - Outputs: PC_ASSERT_bar=0, TX_ASSERT_ADDR_bar=1, MEM_OE_bar=0, MEM_WE_bar=1, STALL=1, BUSY=1, DONE=1.
  - REQ is ignored. Go to IDLE.
- Bus invariants, required in every state and at reset:
  - PC_ASSERT_bar and TX_ASSERT_ADDR_bar are never both 0 and never both 1.
  - MEM_WE_bar=0 implies MEM_OE_bar=1.
  - MEM_WE_bar is 1 in SETUP and RECOVER, so address is stable around the write strobe.
- HALT:
  - HALT only gates acceptance in IDLE.
  - An access already past IDLE completes normally.
- REQ_WRITE is sampled only on the accepting edge. Changes during an access have no effect.

## Timing
- Reset values, in IDLE: PC_ASSERT_bar=0, TX_ASSERT_ADDR_bar=1, MEM_OE_bar=0, MEM_WE_bar=1, DATA_LOAD=0, STALL=0, BUSY=0, DONE=0. CNT=0, DIR=0.
- RST=1 at any edge forces IDLE after that edge, including mid-ACCESS write. MEM_WE_bar returns to 1 the cycle after that edge. No DONE or DATA_LOAD is issued for the aborted access.
- Latency, with REQ accepted at edge n:
  - SETUP is visible n..n+1.
  - ACCESS is visible for W cycles, where W = READ_WAIT or WRITE_WAIT.
  - RECOVER is visible for one cycle; IDLE follows.
  - BUSY/STALL are high for exactly W+2 cycles.
- DATA_LOAD is high during the last ACCESS cycle, so the destination latches at the edge leaving ACCESS.
- DONE is high for the single RECOVER cycle.
- Back-to-back requests: if REQ is still 1 at the first IDLE edge after RECOVER, a new access is accepted. There is a minimum of one IDLE cycle between accesses, guaranteeing one instruction fetch slot.
- Requesters deassert REQ in the cycle DONE is seen to avoid a repeat access.
- The counter never wraps: it is reloaded in SETUP and only decrements in ACCESS.

## Test plan
- Reset: hold RST=1 for 2 cycles with REQ=1 -> all outputs at reset values, BUSY=0, no SETUP.
- Read, READ_WAIT=1: REQ=1, REQ_WRITE=0 for one edge -> SETUP 1 cycle, ACCESS 1 cycle with DATA_LOAD=1 and MEM_OE_bar=0, RECOVER with DONE=1, BUSY high exactly 3 cycles, TX_ASSERT_ADDR_bar=0 exactly 2 cycles.
- Write, WRITE_WAIT=2: REQ=1, REQ_WRITE=1 -> MEM_WE_bar=0 exactly 2 cycles, MEM_OE_bar=1 in SETUP and ACCESS, DATA_LOAD never 1, BUSY 4 cycles.
- Back-to-back: REQ held high across DONE -> exactly one IDLE cycle with PC_ASSERT_bar=0 and STALL=0, then second SETUP; REQ_WRITE toggled mid-access has no effect.
- HALT: HALT=1 with REQ=1 in IDLE -> stays IDLE indefinitely. HALT raised during ACCESS -> access completes with DONE.
- Reset mid-write (WRITE_WAIT=3): RST=1 in second ACCESS cycle -> next cycle MEM_WE_bar=1, PC_ASSERT_bar=0, BUSY=0, no DONE pulse. Bus invariants are checked by assertion every cycle.
